// File: rtl/mbf_pkg.sv
// Shared constants, coefficient tables and valid-tracker state type for the
// two-band synthesis filter bank (mbf_synth).
package mbf_pkg;

   localparam int DATA_W = 13;
   localparam int COEF_W = 5;
   localparam int TAPS   = 12;
   localparam int ACC_W  = 23;
   localparam int SHIFT  = 9;
   localparam int PROD_W = DATA_W + COEF_W;

   typedef logic [TAPS-1:0][COEF_W-1:0] coef_arr_t;

   // Listed tap 11 first so that GL[0]=31 and GH[0]=17 (time-reversed analysis taps).
   localparam coef_arr_t GL = {5'd27, 5'd19, 5'd5,  5'd9,  5'd21, 5'd17,
                               5'd16, 5'd19, 5'd11, 5'd12, 5'd16, 5'd31};
   localparam coef_arr_t GH = {5'd14, 5'd4,  5'd3,  5'd1,  5'd16, 5'd14,
                               5'd28, 5'd16, 5'd31, 5'd28, 5'd31, 5'd17};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } vstate_t;

   localparam logic [ACC_W-SHIFT:0] DATA_MAX =
      {{(ACC_W-SHIFT+1-DATA_W){1'b0}}, {DATA_W{1'b1}}};

   function automatic logic [DATA_W-1:0] sat_data(input logic [ACC_W-SHIFT:0] v);
      if (v > DATA_MAX) begin
         return {DATA_W{1'b1}};
      end else begin
         return v[DATA_W-1:0];
      end
   endfunction

endpackage

// File: rtl/mbf_synth_branch.sv
// One synthesis branch: 12-entry delay line, fixed-coefficient multipliers
// with registered products (S1), and a combinational partial sum.
module mbf_synth_branch
   import mbf_pkg::*;
#(
   parameter coef_arr_t COEFS = GL
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] sample,
   output logic [ACC_W-1:0]  part_sum
);

   logic [TAPS-1:0][DATA_W-1:0] dline;
   logic [TAPS-1:0][PROD_W-1:0] prod;

   // Delay line shift (invalid slots load zero) and S1 product registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dline <= '0;
         prod  <= '0;
      end else begin
         dline <= {dline[TAPS-2:0], (in_valid ? sample : {DATA_W{1'b0}})};
         for (int k = 0; k < TAPS; k++) begin
            prod[k] <= PROD_W'(dline[k]) * PROD_W'(COEFS[k]);
         end
      end
   end

   // Branch partial sum; worst case 203*8191 fits comfortably in ACC_W.
   always_comb begin
      part_sum = {ACC_W{1'b0}};
      for (int k = 0; k < TAPS; k++) begin
         part_sum = part_sum + ACC_W'(prod[k]);
      end
   end

endmodule

// File: rtl/mbf_synth.sv
// Two-band synthesis filter bank top: branch sum (S2), scale/round/saturate
// (S3) and the valid tracker. Define MBF_SYNTH_ROUND_EN for round-half-up.
module mbf_synth
   import mbf_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              IN_VALID,
   input  logic [DATA_W-1:0] X_DATA,
   input  logic [DATA_W-1:0] Y_DATA,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              OUT_VALID
);

   logic [ACC_W-1:0]     low_sum;
   logic [ACC_W-1:0]     high_sum;
   logic [ACC_W-1:0]     sum_r;
   logic [ACC_W-SHIFT:0] scaled;
   logic                 unused_bits;
   vstate_t              state;
   logic [3:0]           cnt;
   logic [1:0]           live_d;

   mbf_synth_branch #(.COEFS(GL)) u_low (
      .clk      (CLK),
      .rst_n    (RESET),
      .in_valid (IN_VALID),
      .sample   (Y_DATA),
      .part_sum (low_sum)
   );

   mbf_synth_branch #(.COEFS(GH)) u_high (
      .clk      (CLK),
      .rst_n    (RESET),
      .in_valid (IN_VALID),
      .sample   (X_DATA),
      .part_sum (high_sum)
   );

   // Scale the accumulated sum down by SHIFT, optionally rounding half up.
   always_comb begin
`ifdef MBF_SYNTH_ROUND_EN
      scaled = {1'b0, sum_r[ACC_W-1:SHIFT]} + {{(ACC_W-SHIFT){1'b0}}, sum_r[SHIFT-1]};
`else
      scaled = {1'b0, sum_r[ACC_W-1:SHIFT]};
`endif
   end

   assign unused_bits = ^sum_r[SHIFT-1:0];

   // S2 sum register and S3 saturated output register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sum_r    <= {ACC_W{1'b0}};
         OUT_DATA <= {DATA_W{1'b0}};
      end else begin
         sum_r    <= low_sum + high_sum;
         OUT_DATA <= sat_data(scaled);
      end
   end

   // Valid tracker: stays live 11 cycles past the last valid input, then a
   // 3-stage delay aligns OUT_VALID with the data pipeline.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         live_d    <= 2'b00;
         OUT_VALID <= 1'b0;
      end else begin
         live_d    <= {live_d[0], (state != ST_IDLE)};
         OUT_VALID <= live_d[1];
         case (state)
            ST_IDLE: begin
               if (IN_VALID) begin
                  state <= ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (IN_VALID) begin
                  state <= ST_RUN;
               end else begin
                  state <= ST_FLUSH;
                  cnt   <= 4'd10;
               end
            end
            ST_FLUSH: begin
               if (IN_VALID) begin
                  state <= ST_RUN;
               end else if (cnt == 4'd0) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mbf_synth.sv
// Self-checking bench for mbf_synth: convolution scoreboard plus directed
// checks of impulse responses, full scale, valid windows and async reset.
module tb_mbf_synth;

   logic        CLK;
   logic        RESET;
   logic        IN_VALID;
   logic [12:0] X_DATA;
   logic [12:0] Y_DATA;
   logic [12:0] OUT_DATA;
   logic        OUT_VALID;

   mbf_synth dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .IN_VALID  (IN_VALID),
      .X_DATA    (X_DATA),
      .Y_DATA    (Y_DATA),
      .OUT_DATA  (OUT_DATA),
      .OUT_VALID (OUT_VALID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int gl[12] = '{31, 16, 12, 11, 19, 16, 17, 21, 9, 5, 19, 27};
   int gh[12] = '{17, 31, 28, 31, 16, 28, 14, 16, 1, 3, 4, 14};

   int hx[12];
   int hy[12];
   bit hv[12];
   int exp_d[$];
   bit exp_v[$];
   int dlog[$];
   int windows[$];
   int run_len;
   int errors;
   int checks;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic void model_clear();
      for (int j = 0; j < 12; j++) begin
         hx[j] = 0;
         hy[j] = 0;
         hv[j] = 1'b0;
      end
      exp_d.delete();
      exp_v.delete();
      for (int j = 0; j < 3; j++) begin
         exp_d.push_back(0);
         exp_v.push_back(1'b0);
      end
      run_len = 0;
   endfunction

   // Predicts the output three edges after the sample pair being driven.
   function automatic void model_push(input bit v, input int x, input int y);
      int acc;
      int sc;
      bit vv;
      for (int j = 11; j > 0; j--) begin
         hx[j] = hx[j-1];
         hy[j] = hy[j-1];
         hv[j] = hv[j-1];
      end
      hx[0] = v ? x : 0;
      hy[0] = v ? y : 0;
      hv[0] = v;
      acc = 0;
      vv  = 1'b0;
      for (int j = 0; j < 12; j++) begin
         acc = acc + gl[j] * hy[j] + gh[j] * hx[j];
         vv  = vv | hv[j];
      end
      sc = acc >> 9;
`ifdef MBF_SYNTH_ROUND_EN
      sc = sc + ((acc >> 8) & 1);
`endif
      if (sc > 8191) sc = 8191;
      exp_d.push_back(sc);
      exp_v.push_back(vv);
   endfunction

   task automatic step(input bit v, input int x, input int y);
      int ed;
      bit ev;
      @(negedge CLK);
      IN_VALID = v;
      X_DATA   = 13'(x);
      Y_DATA   = 13'(y);
      model_push(v, x, y);
      @(posedge CLK);
      #1;
      ed = exp_d.pop_front();
      ev = exp_v.pop_front();
      check_value("out_data", 32'(OUT_DATA), 32'(ed));
      check_value("out_valid", 32'(OUT_VALID), 32'(ev));
      dlog.push_back(int'(OUT_DATA));
      if (OUT_VALID) begin
         run_len++;
      end else if (run_len > 0) begin
         windows.push_back(run_len);
         run_len = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 8191), $urandom_range(0, 8191));
   endtask

   task automatic start_test();
      dlog.delete();
      windows.delete();
   endtask

   task automatic check_windows(input string tag, input int n, input int w0, input int w1);
      check_value({tag, "_count"}, 32'(windows.size()), 32'(n));
      if (windows.size() > 0) check_value({tag, "_len0"}, 32'(windows[0]), 32'(w0));
      if (windows.size() > 1) check_value({tag, "_len1"}, 32'(windows[1]), 32'(w1));
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      RESET    = 1'b0;
      IN_VALID = 1'b0;
      X_DATA   = 13'd0;
      Y_DATA   = 13'd0;
      model_clear();
      repeat (3) @(posedge CLK);
      #1;
      check_value("reset_data", 32'(OUT_DATA), 32'd0);
      check_value("reset_valid", 32'(OUT_VALID), 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      idle(6);

      // Low-band impulse
      start_test();
      step(1'b1, 0, 512);
      idle(16);
      for (int i = 0; i < 12; i++) check_value("low_impulse", 32'(dlog[3+i]), 32'(gl[i]));
      check_windows("low_win", 1, 12, 0);

      // High-band impulse
      start_test();
      step(1'b1, 512, 0);
      idle(16);
      for (int i = 0; i < 12; i++) check_value("high_impulse", 32'(dlog[3+i]), 32'(gh[i]));
      check_windows("high_win", 1, 12, 0);

      // Rounding behaviour on a half-scale impulse
      start_test();
      step(1'b1, 0, 256);
      idle(16);
`ifdef MBF_SYNTH_ROUND_EN
      check_value("round_tap0", 32'(dlog[3]), 32'd16);
      check_value("round_tap3", 32'(dlog[6]), 32'd6);
`else
      check_value("round_tap0", 32'(dlog[3]), 32'd15);
      check_value("round_tap3", 32'(dlog[6]), 32'd5);
`endif

      // Full scale held for 20 cycles
      start_test();
      for (int i = 0; i < 20; i++) step(1'b1, 8191, 8191);
      idle(16);
      check_value("full_settle", 32'(dlog[14]), 32'd6495);
      check_value("full_hold", 32'(dlog[22]), 32'd6495);
      check_windows("full_win", 1, 31, 0);

      // Re-entry within the drain window keeps OUT_VALID continuous
      start_test();
      for (int i = 0; i < 3; i++) step(1'b1, $urandom_range(0, 8191), $urandom_range(0, 8191));
      idle(5);
      for (int i = 0; i < 2; i++) step(1'b1, $urandom_range(0, 8191), $urandom_range(0, 8191));
      idle(16);
      check_windows("gap5_win", 1, 21, 0);

      // A 12-cycle gap splits the valid window
      start_test();
      for (int i = 0; i < 3; i++) step(1'b1, $urandom_range(0, 8191), $urandom_range(0, 8191));
      idle(12);
      for (int i = 0; i < 2; i++) step(1'b1, $urandom_range(0, 8191), $urandom_range(0, 8191));
      idle(16);
      check_windows("gap12_win", 2, 14, 13);

      // Asynchronous reset in the middle of a full-scale burst
      start_test();
      for (int i = 0; i < 8; i++) step(1'b1, 8191, 8191);
      #1;
      RESET    = 1'b0;
      IN_VALID = 1'b0;
      #1;
      check_value("midreset_data", 32'(OUT_DATA), 32'd0);
      check_value("midreset_valid", 32'(OUT_VALID), 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      model_clear();
      start_test();
      idle(20);
      check_windows("post_reset_win", 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mbf_synth.md
# mbf_synth

Two-band synthesis filter bank: the reconstruction side of the multi-bank filter. It accepts a high-band sample stream (X_DATA) and a low-band sample stream (Y_DATA). Each stream passes through a fixed 12-tap FIR synthesis filter, and the two branch outputs are summed, scaled and rounded into one reconstructed 13-bit sample stream. A 3-state valid tracker keeps OUT_VALID asserted until the last valid input has drained from the delay lines.

## Interface
- DATA_W, 13: input/output sample width (unsigned)
- COEF_W, 5: coefficient width (unsigned)
- TAPS, 12: taps per branch
- ACC_W, 23: accumulator width
- SHIFT, 9: output right-shift applied to the accumulated sum
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- IN_VALID  in  1  X_DATA/Y_DATA pair valid this cycle
- X_DATA  in  13  high-band sample
- Y_DATA  in  13  low-band sample
- OUT_DATA  out  13  reconstructed sample; reset 0
- OUT_VALID  out  1  OUT_DATA valid; reset 0

## Operation
- Coefficients are fixed. They are the analysis coefficients time-reversed.
  - GL[0..11] = 31,16,12,11,19,16,17,21,9,5,19,27
  - GH[0..11] = 17,31,28,31,16,28,14,16,1,3,4,14
- Delay lines:
  - Each branch has its own 12-entry line dl/dh.
  - On each edge, dl[0] <= IN_VALID ? Y_DATA : 0 and dh[0] <= IN_VALID ? X_DATA : 0. Entries shift 0→11.
- Pipeline:
  - S1 registers 24 products: dl[k]*GL[k] and dh[k]*GH[k], each 18 bits.
  - S2 registers the unsigned sum into ACC_W bits. The maximum sum is 406*8191 = 3,325,546, so there is no overflow.
  - S3: OUT_DATA <= sat(round(sum >> SHIFT)). sat clips to 8191.
- Valid FSM, with states IDLE, RUN and FLUSH and a 4-bit drain counter cnt:
  - IDLE: IN_VALID → RUN.
  - RUN: IN_VALID → RUN. !IN_VALID → FLUSH with cnt <= 10.
  - FLUSH: IN_VALID → RUN. Otherwise, if cnt==0 → IDLE, else cnt--.
  - live = (state != IDLE). live is delayed 3 register stages to form OUT_VALID.
- Boundaries:
  - IN_VALID during FLUSH returns the FSM to RUN, and the drain restarts after the next falling edge of IN_VALID.
  - A gap of 11 or fewer cycles between bursts keeps OUT_VALID continuously high.
  - Data samples while IN_VALID=0 are ignored (zeros enter the delay lines).
- Reset (RESET=0, at any time, including mid-burst): all delay lines, products, sum, FSM, cnt, OUT_DATA and OUT_VALID clear to 0/IDLE immediately and asynchronously.

## Timing
- A sample pair captured at edge k affects OUT_DATA from edge k+3 through edge k+14.
- OUT_VALID rises at edge k+3 for the first valid sample of a burst.
- A burst of N consecutive valid samples produces exactly N+11 consecutive OUT_VALID cycles.
- Throughput is one sample pair per cycle. There is no backpressure.

## Configuration
- MBF_SYNTH_ROUND_EN defined: S3 adds sum[SHIFT-1] after the shift (round half up).
- MBF_SYNTH_ROUND_EN undefined: S3 truncates (sum >> SHIFT only).
- Saturation is always present.

## Structure
- Shared package mbf_pkg holds:
  - DATA_W, COEF_W, TAPS, ACC_W
  - the GL and GH coefficient arrays
  - the FSM state enum
- Sub-module mbf_synth_branch contains one delay line, 12 multipliers and the S1 registers, with a per-branch partial sum. It is instantiated twice, with GL and GH.
- The top level holds the final add, the S2/S3 registers and the valid FSM.

## Test plan
- Reset: drive RESET=0 mid-burst → OUT_DATA=0 and OUT_VALID=0 immediately. After release, with no input, OUT_VALID stays 0.
- Low-band impulse: one cycle of Y_DATA=512, X_DATA=0 → OUT_DATA = 31,16,12,11,19,16,17,21,9,5,19,27 on edges k+3..k+14, with OUT_VALID high exactly those 12 cycles.
- High-band impulse: X_DATA=512 → OUT_DATA = 17,31,28,31,16,28,14,16,1,3,4,14.
- Rounding: Y_DATA=256 impulse.
  - With the macro: 16,8,6,6,…
  - Without the macro: 15,8,6,5,…
- Full scale: X=Y=8191 held for 20 cycles → OUT_DATA settles at 6495 from edge k+14. OUT_VALID is high for 31 cycles.
- Re-entry: a 3-sample burst, a 5-cycle gap, then a 2-sample burst → OUT_VALID is continuous for 3+5+2+11 = 21 cycles. A gap of 12 produces two separate OUT_VALID windows of 14 and 13 cycles.
